// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load responses onto the
// register-file write port. Optional WB_PERF_CNT_EN adds stall/load counters.
module regfile_wb_arbiter #(
    parameter int DATA_W        = 32,
    parameter int REG_ADDR_W    = 5,
    parameter int LD_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid_pi,
    output logic                  alu_ready_po,
    input  logic [REG_ADDR_W-1:0] alu_rd_pi,
    input  logic [DATA_W-1:0]     alu_data_pi,
    input  logic                  ld_issue_pi,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd_pi,
    input  logic                  ld_valid_pi,
    output logic                  ld_ready_po,
    input  logic [REG_ADDR_W-1:0] ld_rd_pi,
    input  logic [DATA_W-1:0]     ld_data_pi,
    input  logic [REG_ADDR_W-1:0] query1_pi,
    input  logic [REG_ADDR_W-1:0] query2_pi,
    output logic                  busy1_po,
    output logic                  busy2_po,
    output logic                  we_po,
    output logic [REG_ADDR_W-1:0] destReg_po,
    output logic [DATA_W-1:0]     writeData_po
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]           alu_stall_cnt_po,
    output logic [31:0]           ld_wr_cnt_po
`endif
);

    localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << REG_ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_FIFO_DEPTH);

    logic [REG_ADDR_W-1:0] fifo_rd_q   [LD_FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_q [LD_FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [NREG-1:0]       sb_q, sb_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     data_q, data_d;

    logic                  full;
    logic                  empty;
    logic                  sel_fifo;
    logic                  sel_alu;
    logic                  push;
    logic                  pop;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0]     head_data;
    logic [REG_ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0]     wr_data;

    // Arbitration: a full FIFO drains first, otherwise ALU beats buffered loads.
    always_comb begin
        full      = (count_q == DEPTH_C);
        empty     = (count_q == '0);
        head_rd   = fifo_rd_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
        sel_fifo  = full || (!alu_valid_pi && !empty);
        sel_alu   = !full && alu_valid_pi;
        push      = ld_valid_pi && !full;
        pop       = sel_fifo;
        wr_rd     = sel_fifo ? head_rd : alu_rd_pi;
        wr_data   = sel_fifo ? head_data : alu_data_pi;
    end

    assign alu_ready_po = !full;
    assign ld_ready_po  = !full;

    // FIFO pointer/count and registered-write next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // rd==0 completes the handshake but never reaches the register file.
        we_d   = (sel_alu || sel_fifo) && (wr_rd != '0);
        dest_d = we_d ? wr_rd : dest_q;
        data_d = we_d ? wr_data : data_q;
    end

    // Pending-load scoreboard: clear on pop, then set on issue so set wins.
    always_comb begin
        sb_d = sb_q;
        if (pop) begin
            sb_d[head_rd] = 1'b0;
        end
        if (ld_issue_pi) begin
            sb_d[ld_issue_rd_pi] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    assign busy1_po = sb_q[query1_pi];
    assign busy2_po = sb_q[query2_pi];

    // Control state with synchronous reset; buffered loads are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sb_q     <= '0;
            we_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sb_q     <= sb_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= ld_rd_pi;
            fifo_data_q[wr_ptr_q] <= ld_data_pi;
        end
    end

    assign we_po        = we_q;
    assign destReg_po   = dest_q;
    assign writeData_po = data_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] ldwr_cnt_q, ldwr_cnt_d;

    // Perf counters: ALU stall cycles and load pops, wrapping naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        ldwr_cnt_d  = ldwr_cnt_q;
        if (alu_valid_pi && full) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (pop) begin
            ldwr_cnt_d = ldwr_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            ldwr_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            ldwr_cnt_q  <= ldwr_cnt_d;
        end
    end

    assign alu_stall_cnt_po = stall_cnt_q;
    assign ld_wr_cnt_po     = ldwr_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, expected writes queued
// in order, a negedge monitor pops and compares every register-file write.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_pi;
    logic        alu_ready_po;
    logic [4:0]  alu_rd_pi;
    logic [31:0] alu_data_pi;
    logic        ld_issue_pi;
    logic [4:0]  ld_issue_rd_pi;
    logic        ld_valid_pi;
    logic        ld_ready_po;
    logic [4:0]  ld_rd_pi;
    logic [31:0] ld_data_pi;
    logic [4:0]  query1_pi;
    logic [4:0]  query2_pi;
    logic        busy1_po;
    logic        busy2_po;
    logic        we_po;
    logic [4:0]  destReg_po;
    logic [31:0] writeData_po;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  started = 1'b0;

    regfile_wb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid_pi   (alu_valid_pi),
        .alu_ready_po   (alu_ready_po),
        .alu_rd_pi      (alu_rd_pi),
        .alu_data_pi    (alu_data_pi),
        .ld_issue_pi    (ld_issue_pi),
        .ld_issue_rd_pi (ld_issue_rd_pi),
        .ld_valid_pi    (ld_valid_pi),
        .ld_ready_po    (ld_ready_po),
        .ld_rd_pi       (ld_rd_pi),
        .ld_data_pi     (ld_data_pi),
        .query1_pi      (query1_pi),
        .query2_pi      (query2_pi),
        .busy1_po       (busy1_po),
        .busy2_po       (busy2_po),
        .we_po          (we_po),
        .destReg_po     (destReg_po),
        .writeData_po   (writeData_po)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.rd = rd;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write must match the next queued expectation.
    always @(negedge clk) begin
        if (started && we_po === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%h want none",
                         destReg_po, writeData_po);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("mon_dest", 32'(destReg_po), 32'(e.rd));
                chk("mon_data", writeData_po, e.d);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        alu_valid_pi   = 1'b0;
        alu_rd_pi      = '0;
        alu_data_pi    = '0;
        ld_issue_pi    = 1'b0;
        ld_issue_rd_pi = '0;
        ld_valid_pi    = 1'b0;
        ld_rd_pi       = '0;
        ld_data_pi     = '0;
        query1_pi      = '0;
        query2_pi      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_we", 32'(we_po), 0);
        chk("rst_dest", 32'(destReg_po), 0);
        chk("rst_data", writeData_po, 0);
        chk("rst_alu_ready", 32'(alu_ready_po), 1);
        chk("rst_ld_ready", 32'(ld_ready_po), 1);
        chk("rst_busy1", 32'(busy1_po), 0);
        started = 1'b1;

        // ALU write
        alu_valid_pi = 1'b1;
        alu_rd_pi    = 5'd5;
        alu_data_pi  = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        #1;
        chk("t1_alu_ready", 32'(alu_ready_po), 1);
        cyc();
        alu_valid_pi = 1'b0;
        #1;
        chk("t1_we", 32'(we_po), 1);
        chk("t1_dest", 32'(destReg_po), 5);
        chk("t1_data", writeData_po, 32'hDEADBEEF);

        // load latency and scoreboard clear
        cyc();
        ld_issue_pi    = 1'b1;
        ld_issue_rd_pi = 5'd7;
        query1_pi      = 5'd7;
        cyc();
        ld_issue_pi = 1'b0;
        #1;
        chk("t2_busy_set", 32'(busy1_po), 1);
        ld_valid_pi = 1'b1;
        ld_rd_pi    = 5'd7;
        ld_data_pi  = 32'h1234;
        expect_wr(5'd7, 32'h1234);
        cyc();
        ld_valid_pi = 1'b0;
        #1;
        chk("t2_busy_hold", 32'(busy1_po), 1);
        chk("t2_no_bypass", 32'(we_po), 0);
        cyc();
        chk("t2_we", 32'(we_po), 1);
        chk("t2_dest", 32'(destReg_po), 7);
        chk("t2_busy_clr", 32'(busy1_po), 0);

        // FIFO fill under continuous ALU traffic
        cyc();
        expect_wr(5'd1, 32'h11);
        expect_wr(5'd2, 32'h22);
        expect_wr(5'd8, 32'h88);
        expect_wr(5'd3, 32'h33);
        expect_wr(5'd9, 32'h99);
        alu_valid_pi = 1'b1;
        alu_rd_pi    = 5'd1;
        alu_data_pi  = 32'h11;
        ld_valid_pi  = 1'b1;
        ld_rd_pi     = 5'd8;
        ld_data_pi   = 32'h88;
        #1;
        chk("t3_w0_alu_ready", 32'(alu_ready_po), 1);
        chk("t3_w0_ld_ready", 32'(ld_ready_po), 1);
        cyc();
        alu_rd_pi   = 5'd2;
        alu_data_pi = 32'h22;
        ld_rd_pi    = 5'd9;
        ld_data_pi  = 32'h99;
        #1;
        chk("t3_w1_alu_ready", 32'(alu_ready_po), 1);
        cyc();
        alu_rd_pi   = 5'd3;
        alu_data_pi = 32'h33;
        ld_valid_pi = 1'b0;
        #1;
        chk("t3_full_alu_ready", 32'(alu_ready_po), 0);
        chk("t3_full_ld_ready", 32'(ld_ready_po), 0);
        cyc();
        chk("t3_resume_alu_ready", 32'(alu_ready_po), 1);
        chk("t3_resume_ld_ready", 32'(ld_ready_po), 1);
        cyc();
        alu_valid_pi = 1'b0;
        repeat (3) cyc();

        // rd==0 from both sources is dropped
        alu_valid_pi = 1'b1;
        alu_rd_pi    = 5'd0;
        alu_data_pi  = 32'hFFFFFFFF;
        ld_valid_pi  = 1'b1;
        ld_rd_pi     = 5'd0;
        ld_data_pi   = 32'hABCD;
        #1;
        chk("t4_alu_ready", 32'(alu_ready_po), 1);
        chk("t4_ld_ready", 32'(ld_ready_po), 1);
        cyc();
        alu_valid_pi = 1'b0;
        ld_valid_pi  = 1'b0;
        #1;
        chk("t4_we_a", 32'(we_po), 0);
        cyc();
        chk("t4_we_b", 32'(we_po), 0);
        cyc();
        chk("t4_we_c", 32'(we_po), 0);
        chk("t4_ld_ready_after", 32'(ld_ready_po), 1);

        // same-cycle set and clear on rd 3
        ld_issue_pi    = 1'b1;
        ld_issue_rd_pi = 5'd3;
        query2_pi      = 5'd3;
        cyc();
        ld_issue_pi = 1'b0;
        ld_valid_pi = 1'b1;
        ld_rd_pi    = 5'd3;
        ld_data_pi  = 32'h333;
        expect_wr(5'd3, 32'h333);
        #1;
        chk("t5_busy_a", 32'(busy2_po), 1);
        cyc();
        ld_valid_pi = 1'b0;
        ld_issue_pi = 1'b1;
        #1;
        chk("t5_busy_b", 32'(busy2_po), 1);
        cyc();
        ld_issue_pi = 1'b0;
        #1;
        chk("t5_set_wins", 32'(busy2_po), 1);
        chk("t5_we", 32'(we_po), 1);
        chk("t5_dest", 32'(destReg_po), 3);
        ld_valid_pi = 1'b1;
        ld_data_pi  = 32'h444;
        expect_wr(5'd3, 32'h444);
        cyc();
        ld_valid_pi = 1'b0;
        cyc();
        chk("t5_busy_clr", 32'(busy2_po), 0);
        cyc();

        // reset with two buffered loads
        query1_pi      = 5'd10;
        query2_pi      = 5'd11;
        ld_issue_pi    = 1'b1;
        ld_issue_rd_pi = 5'd10;
        cyc();
        ld_issue_rd_pi = 5'd11;
        cyc();
        ld_issue_pi  = 1'b0;
        alu_valid_pi = 1'b1;
        alu_rd_pi    = 5'd1;
        alu_data_pi  = 32'h1;
        ld_valid_pi  = 1'b1;
        ld_rd_pi     = 5'd10;
        ld_data_pi   = 32'hA0;
        expect_wr(5'd1, 32'h1);
        expect_wr(5'd2, 32'h2);
        cyc();
        alu_rd_pi   = 5'd2;
        alu_data_pi = 32'h2;
        ld_rd_pi    = 5'd11;
        ld_data_pi  = 32'hB0;
        cyc();
        alu_valid_pi = 1'b0;
        ld_valid_pi  = 1'b0;
        reset        = 1'b1;
        #1;
        chk("t6_full_ld_ready", 32'(ld_ready_po), 0);
        chk("t6_busy1_pre", 32'(busy1_po), 1);
        chk("t6_busy2_pre", 32'(busy2_po), 1);
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_ld_ready", 32'(ld_ready_po), 1);
        chk("t6_busy1", 32'(busy1_po), 0);
        chk("t6_busy2", 32'(busy2_po), 0);
        chk("t6_we", 32'(we_po), 0);
        repeat (6) cyc();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
